// File: rtl/iris_pkg.sv
// Shared types and constants for the Iris test sequencer: FSM states, class/confusion
// geometry and the layout of one stored test sample.
package iris_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_SCORE = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } seq_state_t;

    localparam int         N_CLASSES  = 3;
    localparam logic [1:0] BAD_LABEL  = 2'd3;
    localparam int         CONF_CELLS = 9;
    localparam int         IRIS_DW    = 8;

    // One ROM word at the default feature width, f1 in the LSBs.
    typedef struct packed {
        logic [1:0]                label;
        logic signed [IRIS_DW-1:0] f4;
        logic signed [IRIS_DW-1:0] f3;
        logic signed [IRIS_DW-1:0] f2;
        logic signed [IRIS_DW-1:0] f1;
    } iris_vec_t;

    function automatic logic [3:0] conf_index(input logic [1:0] label, input logic [1:0] pred);
        return 4'(label) * 4'(N_CLASSES) + 4'(pred);
    endfunction

endpackage

// File: rtl/iris_confusion_bank.sv
// Bank of saturating confusion-matrix counters with a synchronous clear, a single
// increment port and a combinational read mux (out-of-range selects read 0).
module iris_confusion_bank
    import iris_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [3:0]    idx_i,
    input  logic [3:0]    rd_sel_i,
    output logic [CW-1:0] rd_data_o
);

    logic [CW-1:0] cell_q [CONF_CELLS];

    // Cell storage: clear wins over increment, increments stop at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CONF_CELLS; i++) begin
                cell_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CONF_CELLS; i++) begin
                if (clr_i) begin
                    cell_q[i] <= '0;
                end else if (inc_i && (idx_i == 4'(i)) && (cell_q[i] != {CW{1'b1}})) begin
                    cell_q[i] <= cell_q[i] + CW'(1);
                end else begin
                    cell_q[i] <= cell_q[i];
                end
            end
        end
    end

    // Read mux.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < CONF_CELLS; i++) begin
            rd_data_o = (rd_sel_i == 4'(i)) ? cell_q[i] : rd_data_o;
        end
    end

endmodule

// File: rtl/iris_test_sequencer.sv
// Walks the sample ROM, drives each feature vector into the classifier with a run/ready
// handshake, and accumulates accuracy and confusion statistics for the pass.
module iris_test_sequencer
    import iris_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SAMPLES = 30,
    parameter int TIMEOUT     = 64,
    parameter int CW          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         mem_rd,
    output logic [7:0]                   mem_addr,
    input  logic [4*DATA_WIDTH+1:0]      mem_rdata,
    output logic signed [DATA_WIDTH-1:0] x1,
    output logic signed [DATA_WIDTH-1:0] x2,
    output logic signed [DATA_WIDTH-1:0] x3,
    output logic signed [DATA_WIDTH-1:0] x4,
    output logic                         run,
    input  logic                         ready_in,
    input  logic [1:0]                   yc_in,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err,
    output logic [CW-1:0]                correct_cnt,
    output logic [CW-1:0]                sample_cnt,
    output logic [CW-1:0]                bad_label_cnt,
    input  logic [3:0]                   conf_sel,
    output logic [CW-1:0]                conf_cnt
);

    localparam int DW = DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    seq_state_t      state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [4*DW-1:0] feat_q, feat_d;
    logic [1:0]      label_q, label_d;
    logic [1:0]      yc_q, yc_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            ready_q;
    logic            terr_q, terr_d;
    logic [CW-1:0]   corr_q, corr_d;
    logic [CW-1:0]   samp_q, samp_d;
    logic [CW-1:0]   bad_q, bad_d;
    logic            run_q, busy_q, done_q, rd_q;
    logic            conf_clr_s, conf_inc_s;
    logic [3:0]      conf_idx_s;

    // Next-state and datapath updates for the sample walk.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        feat_d     = feat_q;
        label_d    = label_q;
        yc_d       = yc_q;
        tmo_d      = tmo_q;
        terr_d     = terr_q;
        corr_d     = corr_q;
        samp_d     = samp_q;
        bad_d      = bad_q;
        conf_clr_s = 1'b0;
        conf_inc_s = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d      = '0;
                    terr_d     = 1'b0;
                    corr_d     = '0;
                    samp_d     = '0;
                    bad_d      = '0;
                    conf_clr_s = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                feat_d  = mem_rdata[4*DW-1:0];
                label_d = mem_rdata[4*DW+1:4*DW];
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Only a fresh rising edge counts; a level left over from earlier is ignored.
                if (ready_in && !ready_q) begin
                    yc_d    = yc_in;
                    state_d = S_SCORE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_SCORE: begin
                samp_d = sat_inc(samp_q);
                if (label_q == BAD_LABEL) begin
                    bad_d = sat_inc(bad_q);
                end else begin
                    conf_inc_s = (yc_q != 2'd3);
                    corr_d     = (yc_q == label_q) ? sat_inc(corr_q) : corr_q;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == 8'(NUM_SAMPLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            feat_q  <= '0;
            label_q <= 2'd0;
            yc_q    <= 2'd0;
            tmo_q   <= '0;
            ready_q <= 1'b0;
            terr_q  <= 1'b0;
            corr_q  <= '0;
            samp_q  <= '0;
            bad_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            feat_q  <= feat_d;
            label_q <= label_d;
            yc_q    <= yc_d;
            tmo_q   <= tmo_d;
            ready_q <= ready_in;
            terr_q  <= terr_d;
            corr_q  <= corr_d;
            samp_q  <= samp_d;
            bad_q   <= bad_d;
            run_q   <= (state_d == S_RUN);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= (state_d == S_DONE);
            rd_q    <= (state_d == S_FETCH);
        end
    end

    assign conf_idx_s = conf_index(label_q, yc_q);

    iris_confusion_bank #(
        .CW (CW)
    ) u_conf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (conf_clr_s),
        .inc_i     (conf_inc_s),
        .idx_i     (conf_idx_s),
        .rd_sel_i  (conf_sel),
        .rd_data_o (conf_cnt)
    );

    assign mem_rd        = rd_q;
    assign mem_addr      = idx_q;
    assign x1            = feat_q[DW-1:0];
    assign x2            = feat_q[2*DW-1:DW];
    assign x3            = feat_q[3*DW-1:2*DW];
    assign x4            = feat_q[4*DW-1:3*DW];
    assign run           = run_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_err   = terr_q;
    assign correct_cnt   = corr_q;
    assign sample_cnt    = samp_q;
    assign bad_label_cnt = bad_q;

endmodule

// File: doc/iris_test_sequencer.md
Name: iris_test_sequencer

Overview:
- Initiator side of the classifier handshake. It walks a stored test set of Iris samples and drives each 4-feature vector plus run into the network/arg-max pipeline.
- It waits for the ready pulse, captures the class index and scores it against the stored label.
- It accumulates the correct-count and a 3x3 confusion matrix for on-board accuracy measurement.
- It sits between the sample ROM and the net top level.

Parameters:
- DATA_WIDTH, 8, width of each signed feature.
- NUM_SAMPLES, 30, number of samples in the ROM; legal range 1..255.
- TIMEOUT, 64, max cycles from run assertion to ready before abort; must be >= 2.
- CW, 8, width of all result counters; must satisfy 2^CW > NUM_SAMPLES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  launch a pass over all samples; sampled only in IDLE/DONE.
- mem_rd  out  1  ROM read strobe; ROM data is valid the cycle after.
- mem_addr  out  8  ROM sample index.
- mem_rdata  in  4*DATA_WIDTH+2  {label[1:0], f4, f3, f2, f1}, f1 in the LSBs.
- x1..x4  out  DATA_WIDTH each  signed features to the network, held stable while run=1.
- run  out  1  request to the classifier pipeline.
- ready_in  in  1  classifier result-valid, a pulse or level.
- yc_in  in  2  classifier class index, valid when ready_in rises.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE.
- timeout_err  out  1  sticky abort flag.
- correct_cnt  out  CW  number of samples with yc == label.
- sample_cnt  out  CW  number of samples scored.
- bad_label_cnt  out  CW  samples with label == 3.
- conf_sel  in  4  confusion cell select = label*3 + prediction.
- conf_cnt  out  CW  combinational read of the selected cell; 0 if conf_sel >= 9.

Behaviour:
- Reset values:
  - All outputs 0 and state IDLE.
  - Counters, confusion cells, sample index, x1..x4 and timeout_err are all 0.
  - A reset mid-pass drops run immediately (asynchronously) and abandons the pass.
- States: IDLE, FETCH, LOAD, RUN, SCORE, NEXT, DONE.
- IDLE:
  - start=1 clears all counters, confusion cells, timeout_err and the index, then goes to FETCH.
  - busy rises the next cycle.
- FETCH: mem_rd=1, mem_addr=index; always goes to LOAD.
- LOAD: registers x1..x4 and the label from mem_rdata; goes to RUN.
- RUN:
  - run=1. ready_in is registered once (ready_q). A rising edge (ready_in & ~ready_q) captures yc_in and moves to SCORE.
  - A level already high on entry is not accepted; an edge is required.
  - Timeout counter starts at 0 on entry. If it reaches TIMEOUT-1 without an edge, set timeout_err and go to DONE with run=0.
  - Counters keep the values accumulated so far.
- SCORE:
  - run=0 and sample_cnt+1.
  - label == 3: bad_label_cnt+1; no correct or confusion update.
  - Otherwise: cell[label*3+yc]+1; correct_cnt+1 if yc == label.
  - yc == 3 with a valid label: sample_cnt only.
- NEXT: run=0. If index == NUM_SAMPLES-1 go to DONE, else index+1 and go to FETCH.
  - run is therefore low for at least 4 cycles between samples, which lets the classifier return to idle.
- DONE:
  - done=1, busy=0, counters frozen and readable.
  - start=1 begins a new pass exactly as from IDLE (counters cleared); otherwise stay.
- start while busy is ignored.
- ready_in outside RUN is ignored; ready_q still tracks it.
- Counters saturate at 2^CW-1; no wrap.
- Latency per sample = 4 cycles overhead + classifier response time.

Decomposition:
- Package iris_pkg holds:
  - state enum seq_state_t;
  - localparams N_CLASSES=3, BAD_LABEL=2'd3, CONF_CELLS=9;
  - feature vector struct {label, f4, f3, f2, f1} for slicing mem_rdata.
- One sub-module, iris_confusion_bank: 9 saturating CW-bit counters with clear, an increment strobe, a cell index and a combinational read mux.
- The FSM, timeout and handshake logic stay in the top module.

Test Plan:
1. NUM_SAMPLES=3, labels {0,1,2}, model answers yc=label 5 cycles after run -> correct_cnt=3, sample_cnt=3, cells 0/4/8 = 1, done=1, run pulsed exactly 3 times.
2. Labels {0,0,2}, model answers {0,1,1} -> correct_cnt=1, cell1=1, cell7=1, cell0=1, conf_sel=9..15 reads 0.
3. Model never raises ready_in -> run high exactly TIMEOUT cycles, then timeout_err=1, done=1, sample_cnt=0, run=0.
4. ready_in held high before RUN entry, drops, re-rises 3 cycles later -> only the re-rise is accepted; sample scored once.
5. start pulsed during RUN of sample 1 -> ignored, pass completes normally. start in DONE -> counters cleared and a second pass gives identical totals.
6. Label 3 on sample 2 -> bad_label_cnt=1, no confusion update. Assert rst mid-RUN -> run, busy and all counters 0 immediately, state IDLE.
